// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Purpose  : Next-PC selection and IF/ID pipeline latch with fetch checking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter logic [31:0] IM_TOP   = 32'h0000_6FFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic [31:0] instr_f,
   input  logic        stall,
   input  logic        flush,
   input  logic        br_taken,
   input  logic        jump,
   input  logic        jr,
   input  logic [15:0] imm16,
   input  logic [25:0] index26,
   input  logic [31:0] rs_val,
   output logic [31:0] npc,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        valid_d,
   output logic        adel_d,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] c_count_max = 32'hFFFF_FFFF;

   logic [31:0] r_instr_d;
   logic [31:0] r_pc_d;
   logic [31:0] r_pc8_d;
   logic        r_valid_d;
   logic        r_adel_d;
   logic [31:0] r_fetch_count;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_plus8;
   logic [31:0] w_pcd_plus4;
   logic [31:0] w_br_target;
   logic [31:0] w_jump_target;
   logic        w_fault;
   logic [31:0] w_npc;

   assign w_pc_plus4    = pc + 32'd4;
   assign w_pc_plus8    = pc + 32'd8;
   // Redirect targets are relative to the D-stage instruction, not the delay slot at pc.
   assign w_pcd_plus4   = r_pc_d + 32'd4;
   assign w_br_target   = w_pcd_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
   assign w_jump_target = {w_pcd_plus4[31:28], index26, 2'b00};

   assign w_fault = (pc[1:0] != 2'b00) | (pc < IM_BASE) | (pc > IM_TOP);

   always_comb begin
      w_npc = w_pc_plus4;
      if (stall) begin
         w_npc = pc;
      end else if (jr) begin
         w_npc = rs_val;
      end else if (jump) begin
         w_npc = w_jump_target;
      end else if (br_taken) begin
         w_npc = w_br_target;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_instr_d     <= 32'd0;
         r_pc_d        <= PC_RESET;
         r_pc8_d       <= PC_RESET + 32'd8;
         r_valid_d     <= 1'b0;
         r_adel_d      <= 1'b0;
         r_fetch_count <= 32'd0;
      end else if (flush) begin
         r_instr_d <= 32'd0;
         r_pc_d    <= pc;
         r_pc8_d   <= w_pc_plus8;
         r_valid_d <= 1'b0;
         r_adel_d  <= 1'b0;
      end else if (!stall) begin
         // A faulting fetch becomes a NOP carrying the address-error tag.
         r_instr_d <= w_fault ? 32'd0 : instr_f;
         r_pc_d    <= pc;
         r_pc8_d   <= w_pc_plus8;
         r_valid_d <= 1'b1;
         r_adel_d  <= w_fault;
         if (r_fetch_count != c_count_max) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
      end
   end

   assign npc         = w_npc;
   assign instr_d     = r_instr_d;
   assign pc_d        = r_pc_d;
   assign pc8_d       = r_pc8_d;
   assign valid_d     = r_valid_d;
   assign adel_d      = r_adel_d;
   assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Directed and random checks of if_stage against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] instr_f;
   logic        stall;
   logic        flush;
   logic        br_taken;
   logic        jump;
   logic        jr;
   logic [15:0] imm16;
   logic [25:0] index26;
   logic [31:0] rs_val;
   logic [31:0] npc;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        valid_d;
   logic        adel_d;
   logic [31:0] fetch_count;

   int errors = 0;
   int checks = 0;

   // Reference state of the IF/ID latch
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic [31:0] m_pc8;
   logic        m_valid;
   logic        m_adel;
   logic [31:0] m_count;

   if_stage dut (
      .clk(clk), .reset(reset), .pc(pc), .instr_f(instr_f), .stall(stall),
      .flush(flush), .br_taken(br_taken), .jump(jump), .jr(jr), .imm16(imm16),
      .index26(index26), .rs_val(rs_val), .npc(npc), .instr_d(instr_d),
      .pc_d(pc_d), .pc8_d(pc8_d), .valid_d(valid_d), .adel_d(adel_d),
      .fetch_count(fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit is_fault(input logic [31:0] a);
      longint unsigned v;
      v = a;
      return (v % 4 != 0) || (v < 64'h3000) || (v > 64'h6FFF);
   endfunction

   function automatic logic [31:0] ref_npc();
      longint signed off;
      longint unsigned t;
      if (stall) return pc;
      if (jr) return rs_val;
      if (jump) begin
         t = (longint'(m_pc) + 4) & 64'hF000_0000;
         return 32'(t + longint'(index26) * 4);
      end
      if (br_taken) begin
         off = longint'($signed(imm16)) * 4;
         return 32'(longint'(m_pc) + 4 + off);
      end
      return 32'((longint'(pc) + 4) % 64'h1_0000_0000);
   endfunction

   task automatic model_reset();
      m_instr = 32'd0; m_pc = 32'h3000; m_pc8 = 32'h3008;
      m_valid = 1'b0;  m_adel = 1'b0;   m_count = 32'd0;
   endtask

   task automatic model_edge();
      if (flush) begin
         m_instr = 32'd0; m_valid = 1'b0; m_adel = 1'b0;
         m_pc = pc; m_pc8 = 32'(longint'(pc) + 8);
      end else if (!stall) begin
         m_pc = pc; m_pc8 = 32'(longint'(pc) + 8);
         m_valid = 1'b1;
         m_adel = is_fault(pc);
         m_instr = m_adel ? 32'd0 : instr_f;
         if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".instr_d"}, instr_d, m_instr);
      check({tag, ".pc_d"}, pc_d, m_pc);
      check({tag, ".pc8_d"}, pc8_d, m_pc8);
      check({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, m_valid});
      check({tag, ".adel_d"}, {31'd0, adel_d}, {31'd0, m_adel});
      check({tag, ".fetch_count"}, fetch_count, m_count);
   endtask

   // Edge with model update; outputs sampled 1 time unit later.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_regs(tag);
   endtask

   task automatic clear_ctl();
      stall = 0; flush = 0; br_taken = 0; jump = 0; jr = 0;
   endtask

   initial begin
      reset = 0; pc = 32'h3000; instr_f = 32'd0; imm16 = 16'd0;
      index26 = 26'd0; rs_val = 32'd0;
      clear_ctl();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_regs("reset");

      // Free-run after release
      @(negedge clk);
      reset = 1; pc = 32'h3000; instr_f = 32'h2401_0001;
      #1;
      check("npc.seq", npc, 32'h3004);
      step("first");
      check("first.instr", instr_d, 32'h2401_0001);
      check("first.pc8", pc8_d, 32'h3008);
      check("first.count", fetch_count, 32'd1);

      // Branch relative to pc_d
      pc = 32'h3008; instr_f = 32'h1000_0002;
      step("to3008");
      pc = 32'h300C; instr_f = 32'h0000_0000; br_taken = 1; imm16 = 16'hFFFE;
      #1;
      check("npc.br_back", npc, 32'h3004);
      imm16 = 16'h0003;
      #1;
      check("npc.br_fwd", npc, 32'h3018);
      check("npc.br_model", npc, ref_npc());
      step("delay_slot");
      check("delay_slot.pc", pc_d, 32'h300C);
      clear_ctl();

      // Jump then jr priority
      pc = 32'h3010; instr_f = 32'h0800_0C10;
      step("to3010");
      pc = 32'h3014; jump = 1; index26 = 26'h000_0C10;
      #1;
      check("npc.jump", npc, 32'h0000_3040);
      jr = 1; rs_val = 32'h3100;
      #1;
      check("npc.jr", npc, 32'h3100);
      br_taken = 1;
      #1;
      check("npc.all3", npc, 32'h3100);
      step("jr_edge");
      clear_ctl();

      // Stall for three edges
      pc = 32'h3018; stall = 1; instr_f = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("npc.stall", npc, 32'h3018);
         step("stall");
      end
      flush = 1;
      #1;
      check("npc.stall_flush", npc, 32'h3018);
      step("stall_flush");
      check("flush.instr", instr_d, 32'd0);
      clear_ctl();

      // Fetch address errors
      pc = 32'h3002; instr_f = 32'h1234_5678;
      step("misalign");
      check("misalign.adel", {31'd0, adel_d}, 32'd1);
      pc = 32'h7000;
      step("above_top");
      check("above_top.adel", {31'd0, adel_d}, 32'd1);
      pc = 32'h6FFC;
      step("top_word");
      check("top_word.adel", {31'd0, adel_d}, 32'd0);
      pc = 32'h2FFC;
      step("below_base");
      pc = 32'hFFFF_FFFC;
      #1;
      check("npc.wrap", npc, 32'd0);
      step("wrap");

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 9))
            0:       pc = $urandom;
            1:       pc = 32'h3000 + ($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFD);
            default: pc = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
         endcase
         instr_f  = $urandom;
         stall    = ($urandom_range(0, 4) == 0);
         flush    = ($urandom_range(0, 9) == 0);
         br_taken = $urandom_range(0, 1) == 1;
         jump     = ($urandom_range(0, 3) == 0);
         jr       = ($urandom_range(0, 5) == 0);
         imm16    = 16'($urandom);
         index26  = 26'($urandom);
         rs_val   = $urandom;
         #1;
         check("npc.rand", npc, ref_npc());
         step("rand");
      end
      clear_ctl();

      // Asynchronous reset between edges
      @(negedge clk);
      reset = 0;
      #1;
      model_reset();
      check_regs("async0");
      @(negedge clk);
      reset = 1;
      for (int i = 0; i < 5; i++) begin
         pc = 32'h3000 + 32'(i * 4); instr_f = $urandom;
         step("refill");
      end
      check("refill.count", fetch_count, 32'd5);
      #2;
      reset = 0;
      #1;
      model_reset();
      check_regs("async_mid");
      @(negedge clk);
      reset = 1;

      // Saturation of fetch_count
      pc = 32'h3020; instr_f = 32'h0000_0001;
      step("pre_sat");
      @(negedge clk);
      force dut.r_fetch_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_fetch_count;
      m_count = 32'hFFFF_FFFF;
      step("sat1");
      step("sat2");
      check("sat.count", fetch_count, 32'hFFFF_FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
